branch_predictor: RTL and testbench



---
 rtl/branch_predictor.sv | 133 +++++++++++++
 tb/tb_branch_predictor.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Purpose : fetch-stage direct-mapped BTB with 2-bit saturating direction counters.
// Latency : lookup is combinational (zero cycles); updates and flush take effect next cycle.
// Backpr. : none; every update strobe is absorbed in the cycle it is presented.
//
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   pc_f            fetch PC looked up this cycle
//   pred_taken      redirect fetch to pc_pred
//   pc_pred         predicted target (0 on a miss)
//   bp_flush        invalidate every entry on the next edge; wins over an update
//   upd_*           resolved control-flow outcome from execute
//   perf_hits       lookup-hit count   (built only with BP_PERF_CNT_EN, else 0)
//   perf_mispred    mispredict count   (built only with BP_PERF_CNT_EN, else 0)
//
// Optional feature macro: BP_PERF_CNT_EN
module branch_predictor #(
    parameter int BTB_ENTRIES = 64,
    parameter int TAG_W       = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_f,
    output logic        pred_taken,
    output logic [31:0] pc_pred,
    input  logic        bp_flush,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic        upd_taken,
    input  logic        upd_jump,
    input  logic        upd_mispredict,
    output logic [31:0] perf_hits,
    output logic [31:0] perf_mispred
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);

    logic [BTB_ENTRIES-1:0] valid_q;
    logic [1:0]             ctr_q    [BTB_ENTRIES];
    logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
    logic [31:0]            target_q [BTB_ENTRIES];

    logic [IDX_W-1:0] idx_f;
    logic [IDX_W-1:0] idx_u;
    logic [TAG_W-1:0] tag_f;
    logic [TAG_W-1:0] tag_u;
    logic             hit_f;
    logic             hit_u;
    logic             upd_en;

    assign idx_f = pc_f[IDX_W+1:2];
    assign tag_f = pc_f[IDX_W+TAG_W+1:IDX_W+2];
    assign idx_u = upd_pc[IDX_W+1:2];
    assign tag_u = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

    // Lookup reads the registered arrays, so a same-cycle update to the
    // same entry is only seen from the following cycle.
    assign hit_f      = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign pred_taken = hit_f && ctr_q[idx_f][1];
    assign pc_pred    = hit_f ? target_q[idx_f] : 32'h0;

    assign hit_u  = valid_q[idx_u] && (tag_q[idx_u] == tag_u);
    // Tag/target writes are gated with rst as well so a reset landing on an
    // update edge leaves no trace of that update.
    assign upd_en = upd_valid && !bp_flush && !rst;

    // Valid bits and counters: the only array state that needs a reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                ctr_q[i] <= 2'b01;
            end
        end else if (bp_flush) begin
            valid_q <= '0;
        end else if (upd_valid) begin
            if (hit_u) begin
                if (upd_jump) begin
                    ctr_q[idx_u] <= 2'b11;
                end else if (upd_taken) begin
                    if (ctr_q[idx_u] != 2'b11) begin
                        ctr_q[idx_u] <= ctr_q[idx_u] + 2'd1;
                    end
                end else if (ctr_q[idx_u] != 2'b00) begin
                    ctr_q[idx_u] <= ctr_q[idx_u] - 2'd1;
                end
            end else if (upd_taken) begin
                // Only taken outcomes allocate; not-taken misses are ignored.
                valid_q[idx_u] <= 1'b1;
                ctr_q[idx_u]   <= upd_jump ? 2'b11 : 2'b10;
            end
        end
    end

    // Tag and target need no reset: they are masked by valid_q. On a hit the
    // tag rewrite stores the value already present.
    always_ff @(posedge clk) begin
        if (upd_en && upd_taken) begin
            tag_q[idx_u]    <= tag_u;
            target_q[idx_u] <= upd_target;
        end
    end

`ifdef BP_PERF_CNT_EN
    logic [31:0] hits_q;
    logic [31:0] mispred_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hits_q    <= 32'h0;
            mispred_q <= 32'h0;
        end else begin
            if (hit_f) begin
                hits_q <= hits_q + 32'd1;
            end
            if (upd_valid && upd_mispredict && !bp_flush) begin
                mispred_q <= mispred_q + 32'd1;
            end
        end
    end

    assign perf_hits    = hits_q;
    assign perf_mispred = mispred_q;
`else
    assign perf_hits    = 32'h0;
    assign perf_mispred = 32'h0;
`endif

    // PC offset bits and bits above the tag never take part in a lookup.
    logic unused_ok;
    assign unused_ok = ^{pc_f, upd_pc, upd_mispredict};

endmodule

// File: tb/tb_branch_predictor.sv
// Purpose : self-checking bench for branch_predictor (directed + random).
// Latency : expects zero-cycle lookup and next-edge visibility of updates.
// Backpr. : not applicable; stimulus is applied every cycle.
module tb_branch_predictor;

    localparam int ENTRIES = 64;
    localparam int TAG_W   = 10;
    localparam int IDX_W   = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_f;
    logic        pred_taken;
    logic [31:0] pc_pred;
    logic        bp_flush;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic        upd_jump;
    logic        upd_mispredict;
    logic [31:0] perf_hits;
    logic [31:0] perf_mispred;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    branch_predictor #(.BTB_ENTRIES(ENTRIES), .TAG_W(TAG_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_f           (pc_f),
        .pred_taken     (pred_taken),
        .pc_pred        (pc_pred),
        .bp_flush       (bp_flush),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_target     (upd_target),
        .upd_taken      (upd_taken),
        .upd_jump       (upd_jump),
        .upd_mispredict (upd_mispredict),
        .perf_hits      (perf_hits),
        .perf_mispred   (perf_mispred)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit          m_valid [ENTRIES];
    int          m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];   // 0..3, strength of "taken"
    logic [31:0] m_hits;
    logic [31:0] m_mis;

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic int m_tagof(input logic [31:0] pc);
        return int'((pc >> (2 + IDX_W)) % (1 << TAG_W));
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tagof(pc));
    endfunction

    task automatic m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
        m_hits = 32'h0;
        m_mis  = 32'h0;
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            if (m_hit(pc_f)) m_hits = m_hits + 32'd1;
            if (upd_valid && upd_mispredict && !bp_flush) m_mis = m_mis + 32'd1;
            if (bp_flush) begin
                for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
            end else if (upd_valid) begin
                int i;
                i = m_idx(upd_pc);
                if (m_hit(upd_pc)) begin
                    if (upd_jump)       m_ctr[i] = 3;
                    else if (upd_taken) m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                    else                m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                    if (upd_taken) m_tgt[i] = upd_target;
                end else if (upd_taken) begin
                    m_valid[i] = 1'b1;
                    m_tag[i]   = m_tagof(upd_pc);
                    m_tgt[i]   = upd_target;
                    m_ctr[i]   = upd_jump ? 3 : 2;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Single compare process against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            bit          h;
            logic [31:0] e_hits;
            logic [31:0] e_mis;
            h = m_hit(pc_f);
            check("model pred_taken", {31'b0, pred_taken}, {31'b0, h && (m_ctr[m_idx(pc_f)] >= 2)});
            check("model pc_pred", pc_pred, h ? m_tgt[m_idx(pc_f)] : 32'h0);
`ifdef BP_PERF_CNT_EN
            e_hits = m_hits;
            e_mis  = m_mis;
`else
            e_hits = 32'h0;
            e_mis  = 32'h0;
`endif
            check("model perf_hits", perf_hits, e_hits);
            check("model perf_mispred", perf_mispred, e_mis);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt,
                       input logic tk, input logic jmp, input logic mis);
        upd_valid      = 1'b1;
        upd_pc         = pc;
        upd_target     = tgt;
        upd_taken      = tk;
        upd_jump       = jmp;
        upd_mispredict = mis;
        tick();
        upd_valid      = 1'b0;
        upd_mispredict = 1'b0;
    endtask

    task automatic lit(input string name, input logic [31:0] pc,
                       input logic exp_tk, input logic [31:0] exp_pc);
        pc_f = pc;
        #1;
        check({name, " pred_taken"}, {31'b0, pred_taken}, {31'b0, exp_tk});
        check({name, " pc_pred"}, pc_pred, exp_pc);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        p = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2)
          | 32'($urandom_range(0, 3)) | (32'($urandom_range(0, 1)) << 24);
        return p;
    endfunction

    initial begin
        rst = 1'b1;
        m_reset();
        pc_f = 32'h104; bp_flush = 1'b0; upd_valid = 1'b0; upd_pc = 32'h0;
        upd_target = 32'h0; upd_taken = 1'b0; upd_jump = 1'b0; upd_mispredict = 1'b0;
        #1;
        lit("in reset", 32'h104, 1'b0, 32'h0);
        check("in reset perf_hits", perf_hits, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        lit("after reset", 32'h104, 1'b0, 32'h0);

        // Allocate taken conditional: lookup in the same cycle sees the old miss.
        upd(32'h104, 32'h200, 1'b1, 1'b0, 1'b0);
        lit("alloc", 32'h104, 1'b1, 32'h200);

        // 10 -> 01 -> 00 -> 00, then one taken must give 01 (no wrap to 11).
        upd(32'h104, 32'h0, 1'b0, 1'b0, 1'b0);
        lit("nt1", 32'h104, 1'b0, 32'h200);
        upd(32'h104, 32'h0, 1'b0, 1'b0, 1'b0);
        lit("nt2", 32'h104, 1'b0, 32'h200);
        upd(32'h104, 32'h0, 1'b0, 1'b0, 1'b0);
        lit("nt3 sat", 32'h104, 1'b0, 32'h200);
        upd(32'h104, 32'h200, 1'b1, 1'b0, 1'b0);
        lit("tk from 00", 32'h104, 1'b0, 32'h200);
        upd(32'h104, 32'h240, 1'b1, 1'b0, 1'b0);
        lit("tk from 01", 32'h104, 1'b1, 32'h240);

        // Aliasing on idx 1: tag 2 evicts tag 1.
        upd(32'h204, 32'h300, 1'b1, 1'b0, 1'b0);
        lit("alias old", 32'h104, 1'b0, 32'h0);
        lit("alias new", 32'h204, 1'b1, 32'h300);

        // Not-taken miss never allocates.
        upd(32'h508, 32'h900, 1'b0, 1'b0, 1'b0);
        lit("nt miss", 32'h508, 1'b0, 32'h0);

        // Flush wins over a coincident jump update.
        bp_flush = 1'b1;
        upd(32'h110, 32'h400, 1'b1, 1'b1, 1'b0);
        bp_flush = 1'b0;
        lit("flush jump", 32'h110, 1'b0, 32'h0);
        lit("flush old", 32'h204, 1'b0, 32'h0);

`ifdef BP_PERF_CNT_EN
        rst = 1'b1; m_reset(); tick(); rst = 1'b0;
        pc_f = 32'h800;
        upd(32'h104, 32'h200, 1'b1, 1'b0, 1'b1);
        upd(32'h104, 32'h200, 1'b0, 1'b0, 1'b1);
        pc_f = 32'h104;
        repeat (3) tick();
        pc_f = 32'h800;
        #1;
        check("perf hits=3", perf_hits, 32'd3);
        check("perf mispred=2", perf_mispred, 32'd2);
        rst = 1'b1; m_reset();
        #1;
        check("perf hits rst", perf_hits, 32'h0);
        check("perf mispred rst", perf_mispred, 32'h0);
        tick();
        rst = 1'b0;
`endif

        // Random phase, including occasional flush and reset on an update edge.
        for (int n = 0; n < 3000; n++) begin
            pc_f           = rand_pc();
            upd_valid      = ($urandom_range(0, 2) != 0);
            upd_pc         = rand_pc();
            upd_target     = $urandom;
            upd_taken      = ($urandom_range(0, 2) != 0);
            upd_jump       = ($urandom_range(0, 4) == 0);
            upd_mispredict = 1'($urandom_range(0, 1));
            bp_flush       = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                m_reset();
            end else begin
                rst = 1'b0;
            end
            tick();
        end
        rst = 1'b0; upd_valid = 1'b0; bp_flush = 1'b0;
        tick();
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
